// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, packet-locked arbiter in front of a FIFO write port.
// One requester owns the port from grant until its last beat is written.
module fifo_wr_arb #(
  parameter int N  = 4,
  parameter int DW = 104,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  input  logic            fifo_prog_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_din,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  w_grant_nxt;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] w_grant_id_nxt;

  logic          w_locked;
  logic          w_g_valid;
  logic          w_g_last;
  logic          w_xfer;
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [N-1:0]  w_onehot;

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] base,
    input int            k
  );
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign w_locked  = (r_state == S_LOCKED);
  assign w_g_valid = req_valid[r_grant_id];
  assign w_g_last  = req_last[r_grant_id];
  assign w_xfer    = w_locked & w_g_valid & ~fifo_full;

  // Circular search starting just after the most recent winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_grant_id;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req_valid[wrap_add(r_grant_id, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(r_grant_id, k);
      end
    end
  end

  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    unique case (r_state)
      S_IDLE: begin
        if (w_found && !fifo_prog_full) begin
          w_state_nxt    = S_LOCKED;
          w_grant_nxt    = w_onehot;
          w_grant_id_nxt = w_winner;
        end
      end
      S_LOCKED: begin
        if (w_xfer && w_g_last) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= IW'(N-1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  // r_grant is zero outside LOCKED, so it masks ready by itself.
  assign req_ready  = r_grant & {N{w_locked & ~fifo_full}};
  assign fifo_wr_en = w_xfer;
  assign fifo_din   = req_data[int'(r_grant_id)*DW +: DW];
  assign grant      = r_grant;
  assign grant_id   = r_grant_id;
  assign busy       = w_locked;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus random traffic against an
// ownership-based reference model of the arbiter.
module tb_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 104;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_prog_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;

  int            m_owner;
  int            m_last;
  logic [N-1:0]  m_xfer;
  logic [DW-1:0] fq[$];
  int            gq[$];
  int            stalls;

  always #5 clk = ~clk;

  fifo_wr_arb #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .grant          (grant),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    logic         ew;
    logic [N-1:0] eg;
    er = '0;
    ew = 1'b0;
    eg = '0;
    if (m_owner >= 0) begin
      er[m_owner] = !fifo_full;
      ew          = req_valid[m_owner] && !fifo_full;
      eg[m_owner] = 1'b1;
    end
    chk("grant", grant, eg);
    chk("grant_id", grant_id, m_last);
    chk("busy", busy, m_owner >= 0);
    chk("req_ready", req_ready, er);
    chk("wr_en", fifo_wr_en, ew);
    if (ew) chk("din", fifo_din, req_data[m_owner*DW +: DW]);
    if (fifo_wr_en === 1'b1) fq.push_back(fifo_din);
  endtask

  // Inputs are applied 1ns after an edge; outputs checked at the falling edge.
  task automatic cycle();
    #4;
    check_outputs();
    @(posedge clk);
    m_xfer = '0;
    if (m_owner < 0) begin
      if (|req_valid && !fifo_prog_full) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_valid[c]) begin
            m_owner = c;
            m_last  = c;
            break;
          end
        end
      end
    end else if (req_valid[m_owner] && !fifo_full) begin
      m_xfer[m_owner] = 1'b1;
      if (req_last[m_owner]) m_owner = -1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_owner = -1;
    m_last  = N-1;
    m_xfer  = '0;
    chk("rst_grant", grant, 0);
    chk("rst_grant_id", grant_id, N-1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic put(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    reset          = 1'b0;
    req_valid      = '0;
    req_last       = '0;
    req_data       = '0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;
    do_reset();

    // single requester, three beats
    req_valid = 4'b0010;
    put(1, 104'hA);
    cycle();
    chk("t2_grant", grant, 4'b0010);
    fq.delete();
    cycle();
    put(1, 104'hB);
    cycle();
    put(1, 104'hC);
    req_last = 4'b0010;
    cycle();
    req_valid = '0;
    req_last  = '0;
    chk("t2_busy", busy, 1'b0);
    chk("t2_grant_id", grant_id, 1);
    chk("t2_nwords", fq.size(), 3);
    chk("t2_w0", fq[0], 104'hA);
    chk("t2_w1", fq[1], 104'hB);
    chk("t2_w2", fq[2], 104'hC);

    // fairness with single-beat packets
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < N; i++) put(i, DW'(32'hF0 + i));
    fq.delete();
    gq.delete();
    repeat (12) begin
      #2;
      if (busy === 1'b1) gq.push_back(int'(grant_id));
      cycle();
    end
    chk("t3_ngrants", gq.size(), 6);
    chk("t3_nwords", fq.size(), 6);
    for (int j = 0; j < 6; j++) begin
      chk("t3_order", gq[j], j % N);
      chk("t3_src", fq[j], DW'(32'hF0 + (j % N)));
    end

    // asynchronous reset mid-stream with all requesters valid
    do_reset();
    req_valid = '0;
    req_last  = '0;

    // full stall in the middle of a packet from req2
    fq.delete();
    stalls = 0;
    req_valid = 4'b0100;
    put(2, 104'hD0);
    cycle();
    cycle();
    put(2, 104'hD1);
    fifo_full = 1'b1;
    repeat (3) begin
      #2;
      chk("t4_ready2", req_ready[2], 1'b0);
      chk("t4_wr_en", fifo_wr_en, 1'b0);
      cycle();
    end
    fifo_full = 1'b0;
    #2;
    chk("t4_resume", fifo_wr_en, 1'b1);
    cycle();
    put(2, 104'hD2);
    cycle();
    put(2, 104'hD3);
    req_last = 4'b0100;
    cycle();
    req_valid = '0;
    req_last  = '0;
    chk("t4_nwords", fq.size(), 4);
    chk("t4_w0", fq[0], 104'hD0);
    chk("t4_w1", fq[1], 104'hD1);
    chk("t4_w2", fq[2], 104'hD2);
    chk("t4_w3", fq[3], 104'hD3);

    // prog_full in IDLE blocks, in LOCKED is ignored
    fq.delete();
    fifo_prog_full = 1'b1;
    req_valid = 4'b0001;
    put(0, 104'hE0);
    repeat (3) begin
      cycle();
      chk("t5_idle_hold", busy, 1'b0);
    end
    fifo_prog_full = 1'b0;
    cycle();
    chk("t5_grant0", grant, 4'b0001);
    fifo_prog_full = 1'b1;
    cycle();
    put(0, 104'hE1);
    req_last = 4'b0001;
    cycle();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    put(1, 104'hE2);
    repeat (3) begin
      cycle();
      chk("t5_no_regrant", busy, 1'b0);
    end
    chk("t5_nwords", fq.size(), 2);
    fifo_prog_full = 1'b0;
    cycle();
    chk("t5_grant1", grant, 4'b0010);
    cycle();
    req_valid = '0;
    req_last  = '0;

    // locked req3 drops valid while req0 waits
    req_valid = 4'b1000;
    put(3, 104'h30);
    cycle();
    chk("t6_grant3", grant, 4'b1000);
    fq.delete();
    req_valid = 4'b1001;
    req_last  = 4'b0001;
    put(0, 104'h99);
    cycle();
    req_valid = 4'b0001;
    repeat (2) begin
      cycle();
      chk("t6_hold", grant, 4'b1000);
    end
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    put(3, 104'h31);
    cycle();
    chk("t6_nwords", fq.size(), 2);
    chk("t6_w0", fq[0], 104'h30);
    chk("t6_w1", fq[1], 104'h31);
    req_valid = 4'b0001;
    cycle();
    chk("t6_grant0", grant, 4'b0001);
    cycle();
    req_valid = '0;
    req_last  = '0;
    cycle();

    // random traffic
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (m_xfer[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_last[i]  = ($urandom_range(0, 2) == 0);
          put(i, DW'({$urandom(), $urandom(), $urandom(), $urandom()}));
        end
      end
      fifo_full      = ($urandom_range(0, 4) == 0);
      fifo_prog_full = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin arbiter that shares the single write port of a FIFO between N independent requesters. Each requester presents multi-beat packets over a valid/ready handshake. The arbiter locks onto one requester for a whole packet, so beats from different sources never interleave in the FIFO. It respects the FIFO's `full` and `prog_full` flags and sits directly in front of the FIFO write side, in the write clock domain.

## Interface
Parameters:
- `N`, 4, number of requesters (2..16)
- `DW`, 104, data width; must match the FIFO width
- `IW`, `$clog2(N)`, width of the grant index

Ports:
- `clk`  input  1  write-side clock; all state is on the rising edge
- `reset`  input  1  asynchronous, active-high reset
- `req_valid`  input  N  per-requester beat valid
- `req_last`  input  N  per-requester end-of-packet marker, qualified by valid
- `req_data`  input  N*DW  per-requester data; requester i occupies bits `[i*DW +: DW]`
- `req_ready`  output  N  per-requester beat accepted
- `fifo_full`  input  1  FIFO full flag
- `fifo_prog_full`  input  1  FIFO programmable-full flag
- `fifo_wr_en`  output  1  FIFO write enable
- `fifo_din`  output  DW  FIFO write data
- `grant`  output  N  one-hot registered grant; all zero when idle
- `grant_id`  output  IW  registered index of the current or most recent grant
- `busy`  output  1  high while in the LOCKED state

## Operation
- The state machine has two states: IDLE and LOCKED. Reset puts it in IDLE.
- **IDLE:**
  - `grant` = 0 and `busy` = 0. `req_ready` = 0 and `fifo_wr_en` = 0.
  - If `|req_valid` is high and `fifo_prog_full` is low, select the winner and go to LOCKED. On the same edge, register the winner in `grant` and `grant_id`.
  - Winner selection: the first set `req_valid` bit, searching circularly from `grant_id+1` upward and wrapping modulo N.
  - If `fifo_prog_full` is high, stay in IDLE.
- **LOCKED** (granted index g):
  - `req_ready[g]` = ~`fifo_full`; every other `req_ready` bit is 0.
  - `fifo_wr_en` = `req_valid[g]` & ~`fifo_full`.
  - `fifo_din` = `req_data[g]`. The mux is combinational from the registered grant.
  - A transfer is a cycle with `req_valid[g]` and `req_ready[g]` both high.
  - A transfer with `req_last[g]` high returns the state to IDLE on the next edge and clears `grant`. `grant_id` holds g.
- `fifo_prog_full` is ignored in LOCKED. A packet already started always runs to completion, subject only to `fifo_full`.
- If `req_valid[g]` drops in LOCKED, the arbiter stays locked with no write. No other requester is granted until the locked requester's last beat.
- `fifo_din` outside LOCKED is don't-care; drive it with `req_data[grant_id]`.
- `req_last` is ignored when `req_valid` is low, and is ignored for non-granted requesters.

## Timing
- Reset values, applied asynchronously:
  - `grant` = 0, `busy` = 0, state = IDLE.
  - `grant_id` = N-1, so requester 0 wins first.
  - `req_ready` = 0 and `fifo_wr_en` = 0.
- Arbitration latency: a request seen in IDLE at edge k gives `grant` and `busy` high after edge k. The first write can occur in that same cycle.
- Every packet costs one IDLE bubble cycle. An L-beat packet with no stalls occupies L+1 cycles.
- `fifo_wr_en` and `req_ready` follow `fifo_full` combinationally, with no pipeline.
- Releasing `reset` mid-packet: the arbiter restarts in IDLE. The partial packet already in the FIFO is the system's responsibility.
- Wrap-around: with `grant_id` = N-1, the search begins at index 0.

## Test plan
1. Reset check: assert `reset` mid-sim with `req_valid` = 4'b1111 -> `grant` = 0, `grant_id` = 3, `busy` = 0, `fifo_wr_en` = 0 immediately, with no clock needed.
2. Single requester: req1 sends a 3-beat packet A,B,C with last on C -> `grant` = 4'b0010 one cycle after valid; the FIFO receives A,B,C on consecutive cycles; `busy` falls after C; `grant_id` = 1.
3. Fairness: all four requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,1. There is a `fifo_wr_en` every other cycle, and each FIFO word's source matches the grant.
4. Full stall: during beat 2 of a 4-beat packet from req2, hold `fifo_full` high for 3 cycles -> `req_ready[2]` = 0 and `fifo_wr_en` = 0 for exactly 3 cycles, and the data is not duplicated or dropped.
5. prog_full: assert `fifo_prog_full` in IDLE with req0 valid -> no grant until it drops. Assert it in LOCKED -> the current packet completes, and no new grant is made until it drops.
6. Non-interleave: req3 is locked mid-packet with valid deasserted for 2 cycles while req0 stays valid -> `grant` stays 4'b1000, with no req0 beats in the FIFO until req3's last beat.
